// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port and full/empty flags.
// Optional sticky overflow/underflow outputs are enabled with SYNCFIFO_ERR_FLAGS_EN.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] out
`ifdef SYNCFIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come straight off the registered count, so they settle one edge after the access.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= in;
    end
  end

  // NOTE: every register uses <= so all state updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        out    <= mem[rd_ptr];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNCFIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo against a queue-based reference model.
// Checks the sticky error flags too when SYNCFIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             wr_en;
  logic             rd_en;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] out;
`ifdef SYNCFIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .full      (full),
    .empty     (empty),
    .out       (out)
`ifdef SYNCFIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  int tests = 0;
  int fails = 0;
  string phase = "init";

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_out;
  bit               model_ovf;
  bit               model_unf;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("FAIL %s/%s: got %0h expected %0h (t=%0t)", phase, tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, update the model at the rising edge, compare after it.
  task automatic cycle(input bit rst, input bit w, input bit r, input logic [WIDTH-1:0] d);
    bit can_w;
    bit can_r;
    @(negedge clk);
    reset = rst;
    wr_en = w;
    rd_en = r;
    in    = d;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_out = '0;
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      can_w = w && (model_q.size() < DEPTH);
      can_r = r && (model_q.size() > 0);
      if (w && model_q.size() == DEPTH) model_ovf = 1'b1;
      if (r && model_q.size() == 0) model_unf = 1'b1;
      if (can_r) model_out = model_q.pop_front();
      if (can_w) model_q.push_back(d);
    end
    #1;
    check("out", 32'(out), 32'(model_out));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("full", 32'(full), 32'(model_q.size() == DEPTH));
`ifdef SYNCFIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(model_ovf));
    check("underflow", 32'(underflow), 32'(model_unf));
`endif
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, WIDTH'($urandom));
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, WIDTH'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    in    = '0;
    model_out = '0;
    model_ovf = 1'b0;
    model_unf = 1'b0;

    phase = "reset";
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("empty_after_reset", 32'(empty), 32'd1);
    check("out_after_reset", 32'(out), 32'd0);
    read_n(3);

    phase = "overfill";
    cycle(1'b1, 1'b0, 1'b0, '0);
    write_n(18);
    check("full_after_18", 32'(full), 32'd1);

    phase = "drain";
    read_n(20);
    check("empty_after_20", 32'(empty), 32'd1);

    phase = "wrap";
    for (int p = 0; p < 3; p++) begin
      write_n(18);
      read_n(18);
    end

    phase = "simul_mid";
    write_n(5);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, WIDTH'($urandom));
    check("depth_held_5", 32'(model_q.size()), 32'd5);
    read_n(6);

    phase = "simul_empty";
    cycle(1'b0, 1'b1, 1'b1, WIDTH'($urandom));
    read_n(2);

    phase = "simul_full";
    write_n(DEPTH);
    cycle(1'b0, 1'b1, 1'b1, WIDTH'($urandom));
    check("full_dropped", 32'(full), 32'd0);
    read_n(DEPTH);

    phase = "reset_mid";
    write_n(8);
    cycle(1'b1, 1'b1, 1'b1, WIDTH'($urandom));
    check("empty_mid_reset", 32'(empty), 32'd1);
    check("out_mid_reset", 32'(out), 32'd0);
    read_n(2);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      cycle(1'b0, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), WIDTH'($urandom));
    end
    read_n(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
